// File: rtl/load_store_unit.sv
// Memory stage: runs the data-memory req/ack handshake for loads and stores,
// aligns and extends load data, builds store strobes, and passes non-memory
// ALU results straight through to writeback after one registered cycle.
module load_store_unit #(
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [4:0]  opcode,
  input  logic [2:0]  func3,
  input  logic [31:0] alu_out,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  input  logic        wb_en_in,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_wstrb,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        stall,
  output logic        wb_valid,
  output logic        wb_we,
  output logic        wb_fp,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;
  localparam logic [4:0] OP_FLW   = 5'b00001;
  localparam logic [4:0] OP_FSW   = 5'b01001;

  // State and captured access context.
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  size_t            size_q, size_d;
  logic             uns_q, uns_d;
  logic [1:0]       lane_q, lane_d;
  logic [4:0]       rd_q, rd_d;
  logic             wb_en_q, wb_en_d;
  logic             fp_q, fp_d;

  // Next values for the registered outputs.
  logic        dm_req_d, dm_we_d;
  logic [31:0] dm_addr_d, dm_wdata_d;
  logic [3:0]  dm_wstrb_d;
  logic        wb_valid_d, wb_we_d, wb_fp_d;
  logic [4:0]  wb_rd_d;
  logic [31:0] wb_data_d;
  logic        misalign_d, bus_err_d;

  // Decode of the op presented in IDLE.
  logic        is_load, is_store, is_mem, is_fp_op, mis_in;
  size_t       size_in;
  logic [3:0]  wstrb_in;
  logic [31:0] wdata_in;
  logic [CNT_W:0] cnt_inc;
  logic        timeout_hit;

  // Select and extend the addressed byte/halfword from a read word.
  function automatic logic [31:0] fmt_load(input logic [31:0] rdata,
                                           input logic [1:0]  lane,
                                           input size_t       sz,
                                           input logic        uns);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = rdata >> {lane, 3'b000};
    b = shifted[7:0];
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (sz)
      SZ_B:    return uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_H:    return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return rdata;
    endcase
  endfunction

  // Op decode, alignment check and store lane formatting.
  always_comb begin
    is_load  = (opcode == OP_LOAD)  || (opcode == OP_FLW);
    is_store = (opcode == OP_STORE) || (opcode == OP_FSW);
    is_mem   = is_load || is_store;
    is_fp_op = (opcode == OP_FLW) || (opcode == OP_FSW);
    if (is_fp_op) begin
      size_in = SZ_W;
    end else begin
      case (func3)
        3'b000, 3'b100: size_in = SZ_B;
        3'b001, 3'b101: size_in = SZ_H;
        default:        size_in = SZ_W;  // W and unlisted encodings
      endcase
    end
    mis_in = ((size_in == SZ_H) && alu_out[0]) ||
             ((size_in == SZ_W) && (alu_out[1:0] != 2'b00));
    case (size_in)
      SZ_B: begin
        wstrb_in = 4'b0001 << alu_out[1:0];
        wdata_in = {4{store_data[7:0]}};
      end
      SZ_H: begin
        wstrb_in = alu_out[1] ? 4'b1100 : 4'b0011;
        wdata_in = {2{store_data[15:0]}};
      end
      default: begin
        wstrb_in = 4'b1111;
        wdata_in = store_data;
      end
    endcase
    cnt_inc     = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    timeout_hit = (cnt_inc == (CNT_W + 1)'(ACK_TIMEOUT));
  end

  // Next-state and next-output logic.
  // NOTE: every signal gets a default before the case so no path leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    size_d     = size_q;
    uns_d      = uns_q;
    lane_d     = lane_q;
    rd_d       = rd_q;
    wb_en_d    = wb_en_q;
    fp_d       = fp_q;
    dm_req_d   = dm_req;
    dm_we_d    = dm_we;
    dm_addr_d  = dm_addr;
    dm_wstrb_d = dm_wstrb;
    dm_wdata_d = dm_wdata;
    wb_valid_d = 1'b0;
    wb_we_d    = 1'b0;
    wb_fp_d    = 1'b0;
    wb_rd_d    = 5'd0;
    wb_data_d  = 32'd0;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_data_d  = alu_out;
            wb_we_d    = wb_en_in;
            wb_rd_d    = rd_in;
          end else if (mis_in) begin
            misalign_d = 1'b1;
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_in;
          end else begin
            state_d    = WAIT;
            cnt_d      = '0;
            size_d     = size_in;
            uns_d      = func3[2];
            lane_d     = alu_out[1:0];
            rd_d       = rd_in;
            wb_en_d    = wb_en_in && is_load;
            fp_d       = is_fp_op && is_load;
            dm_req_d   = 1'b1;
            dm_we_d    = is_store;
            dm_addr_d  = {alu_out[31:2], 2'b00};
            dm_wstrb_d = is_store ? wstrb_in : 4'b0000;
            dm_wdata_d = is_store ? wdata_in : 32'd0;
          end
        end
      end
      WAIT: begin
        if (dm_ack || timeout_hit) begin
          dm_req_d   = 1'b0;
          dm_we_d    = 1'b0;
          dm_addr_d  = 32'd0;
          dm_wstrb_d = 4'b0000;
          dm_wdata_d = 32'd0;
          cnt_d      = '0;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          if (dm_ack) begin
            // Ack wins over a coincident timeout.
            state_d   = RESP;
            wb_we_d   = wb_en_q;
            wb_fp_d   = fp_q;
            wb_data_d = dm_we ? 32'd0 : fmt_load(dm_rdata, lane_q, size_q, uns_q);
          end else begin
            state_d   = IDLE;
            bus_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end
      RESP: begin
        // Hold the writeback pulse registered at the ack edge for this cycle.
        state_d    = IDLE;
        wb_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, context and output registers.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      size_q   <= SZ_B;
      uns_q    <= 1'b0;
      lane_q   <= 2'b00;
      rd_q     <= 5'd0;
      wb_en_q  <= 1'b0;
      fp_q     <= 1'b0;
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= 32'd0;
      dm_wstrb <= 4'b0000;
      dm_wdata <= 32'd0;
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_fp    <= 1'b0;
      wb_rd    <= 5'd0;
      wb_data  <= 32'd0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      lane_q   <= lane_d;
      rd_q     <= rd_d;
      wb_en_q  <= wb_en_d;
      fp_q     <= fp_d;
      dm_req   <= dm_req_d;
      dm_we    <= dm_we_d;
      dm_addr  <= dm_addr_d;
      dm_wstrb <= dm_wstrb_d;
      dm_wdata <= dm_wdata_d;
      wb_valid <= wb_valid_d;
      wb_we    <= wb_we_d;
      wb_fp    <= wb_fp_d;
      wb_rd    <= wb_rd_d;
      wb_data  <= wb_data_d;
      misalign <= misalign_d;
      bus_err  <= bus_err_d;
    end
  end

  assign stall = (state_q != IDLE);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: pass-through, loads, stores,
// misalignment, ack timeout, ack-vs-timeout priority and mid-access reset.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [4:0]  opcode;
  logic [2:0]  func3;
  logic [31:0] alu_out;
  logic [31:0] store_data;
  logic [4:0]  rd_in;
  logic        wb_en_in;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        stall;
  logic        wb_valid;
  logic        wb_we;
  logic        wb_fp;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign;
  logic        bus_err;

  int checks   = 0;
  int failures = 0;

  load_store_unit #(.ACK_TIMEOUT(255), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .opcode(opcode),
    .func3(func3), .alu_out(alu_out), .store_data(store_data),
    .rd_in(rd_in), .wb_en_in(wb_en_in), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wstrb(dm_wstrb), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .stall(stall),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_fp(wb_fp), .wb_rd(wb_rd),
    .wb_data(wb_data), .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single accept cycle.
  task automatic issue(input logic [4:0] op, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] sd, input logic [4:0] rd, input logic en);
    ex_valid   = 1'b1;
    opcode     = op;
    func3      = f3;
    alu_out    = addr;
    store_data = sd;
    rd_in      = rd;
    wb_en_in   = en;
    tick();
    ex_valid   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},   {31'd0, dm_req},   32'd0);
    check({tag, "_we"},    {31'd0, dm_we},    32'd0);
    check({tag, "_addr"},  dm_addr,           32'd0);
    check({tag, "_wstrb"}, {28'd0, dm_wstrb}, 32'd0);
    check({tag, "_wdata"}, dm_wdata,          32'd0);
    check({tag, "_stall"}, {31'd0, stall},    32'd0);
    check({tag, "_wbv"},   {31'd0, wb_valid}, 32'd0);
    check({tag, "_wbwe"},  {31'd0, wb_we},    32'd0);
    check({tag, "_wbfp"},  {31'd0, wb_fp},    32'd0);
    check({tag, "_wbrd"},  {27'd0, wb_rd},    32'd0);
    check({tag, "_wbd"},   wb_data,           32'd0);
    check({tag, "_mis"},   {31'd0, misalign}, 32'd0);
    check({tag, "_berr"},  {31'd0, bus_err},  32'd0);
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; opcode = '0; func3 = '0; alu_out = '0;
    store_data = '0; rd_in = '0; wb_en_in = 1'b0; dm_ack = 1'b0; dm_rdata = '0;

    // Reset state.
    tick();
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ADD pass-through, then a back-to-back second op.
    issue(5'b01100, 3'b000, 32'h0000_0010, 32'h0, 5'd5, 1'b1);
    check("add_valid", {31'd0, wb_valid}, 32'd1);
    check("add_rd",    {27'd0, wb_rd},    32'd5);
    check("add_data",  wb_data,           32'h10);
    check("add_we",    {31'd0, wb_we},    32'd1);
    check("add_stall", {31'd0, stall},    32'd0);
    issue(5'b00100, 3'b000, 32'hCAFE_0001, 32'h0, 5'd6, 1'b0);
    check("b2b_valid", {31'd0, wb_valid}, 32'd1);
    check("b2b_data",  wb_data,           32'hCAFE_0001);
    check("b2b_we",    {31'd0, wb_we},    32'd0);
    tick();
    check("idle_valid", {31'd0, wb_valid}, 32'd0);

    // LB at 0x103, ack after 3 WAIT cycles.
    issue(5'b00000, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 1'b1);
    check("lb_req",   {31'd0, dm_req},   32'd1);
    check("lb_addr",  dm_addr,           32'h100);
    check("lb_wstrb", {28'd0, dm_wstrb}, 32'd0);
    check("lb_we",    {31'd0, dm_we},    32'd0);
    check("lb_stall", {31'd0, stall},    32'd1);
    tick();
    tick();
    check("lb_wait_req",   {31'd0, dm_req},   32'd1);
    check("lb_wait_stall", {31'd0, stall},    32'd1);
    check("lb_wait_wbv",   {31'd0, wb_valid}, 32'd0);
    dm_ack = 1'b1; dm_rdata = 32'h80FF_1234;
    tick();
    dm_ack = 1'b0;
    check("lb_resp_wbv",  {31'd0, wb_valid}, 32'd1);
    check("lb_resp_data", wb_data,           32'hFFFF_FF80);
    check("lb_resp_rd",   {27'd0, wb_rd},    32'd7);
    check("lb_resp_we",   {31'd0, wb_we},    32'd1);
    check("lb_resp_req",  {31'd0, dm_req},   32'd0);
    tick();
    check("lb_done_stall", {31'd0, stall},    32'd0);
    check("lb_done_wbv",   {31'd0, wb_valid}, 32'd0);

    // LHU at 0x102, immediate ack.
    issue(5'b00000, 3'b101, 32'h0000_0102, 32'h0, 5'd8, 1'b1);
    dm_ack = 1'b1; dm_rdata = 32'hBEEF_0000;
    tick();
    dm_ack = 1'b0;
    check("lhu_data", wb_data, 32'h0000_BEEF);
    tick();

    // LH at 0x100 sign-extends the low halfword.
    issue(5'b00000, 3'b001, 32'h0000_0100, 32'h0, 5'd9, 1'b1);
    dm_ack = 1'b1; dm_rdata = 32'h1111_8001;
    tick();
    dm_ack = 1'b0;
    check("lh_data", wb_data, 32'hFFFF_8001);
    tick();

    // FLW routes to the FP register file.
    issue(5'b00001, 3'b010, 32'h0000_0104, 32'h0, 5'd3, 1'b1);
    dm_ack = 1'b1; dm_rdata = 32'hDEAD_BEEF;
    tick();
    dm_ack = 1'b0;
    check("flw_data", wb_data,         32'hDEAD_BEEF);
    check("flw_fp",   {31'd0, wb_fp},  32'd1);
    check("flw_we",   {31'd0, wb_we},  32'd1);
    tick();

    // SH at 0x202.
    issue(5'b01000, 3'b001, 32'h0000_0202, 32'h1234_5678, 5'd0, 1'b0);
    check("sh_we",    {31'd0, dm_we},    32'd1);
    check("sh_addr",  dm_addr,           32'h200);
    check("sh_wstrb", {28'd0, dm_wstrb}, 32'hC);
    check("sh_wdata", dm_wdata,          32'h5678_5678);
    dm_ack = 1'b1;
    tick();
    dm_ack = 1'b0;
    check("sh_resp_wbv", {31'd0, wb_valid}, 32'd1);
    check("sh_resp_we",  {31'd0, wb_we},    32'd0);
    tick();

    // SB at 0x201 and FSW at 0x300.
    issue(5'b01000, 3'b000, 32'h0000_0201, 32'h0000_00AB, 5'd0, 1'b0);
    check("sb_wstrb", {28'd0, dm_wstrb}, 32'h2);
    check("sb_wdata", dm_wdata,          32'hABAB_ABAB);
    dm_ack = 1'b1; tick(); dm_ack = 1'b0; tick();
    issue(5'b01001, 3'b010, 32'h0000_0300, 32'h3F80_0000, 5'd0, 1'b0);
    check("fsw_wstrb", {28'd0, dm_wstrb}, 32'hF);
    check("fsw_wdata", dm_wdata,          32'h3F80_0000);
    dm_ack = 1'b1; tick(); dm_ack = 1'b0; tick();

    // SW at 0x301 is misaligned; an ADD is accepted the very next cycle.
    issue(5'b01000, 3'b010, 32'h0000_0301, 32'hFFFF_FFFF, 5'd0, 1'b0);
    check("sw_mis",   {31'd0, misalign}, 32'd1);
    check("sw_wbv",   {31'd0, wb_valid}, 32'd1);
    check("sw_wbwe",  {31'd0, wb_we},    32'd0);
    check("sw_req",   {31'd0, dm_req},   32'd0);
    check("sw_stall", {31'd0, stall},    32'd0);
    issue(5'b01100, 3'b000, 32'h0000_0042, 32'h0, 5'd4, 1'b1);
    check("after_mis_data", wb_data,           32'h42);
    check("after_mis_mis",  {31'd0, misalign}, 32'd0);
    // LH at odd address also misaligned.
    issue(5'b00000, 3'b001, 32'h0000_0101, 32'h0, 5'd4, 1'b1);
    check("lh_mis", {31'd0, misalign}, 32'd1);
    tick();

    // LW with no ack: bus_err after 255 WAIT cycles.
    issue(5'b00000, 3'b010, 32'h0000_0400, 32'h0, 5'd10, 1'b1);
    for (int i = 0; i < 254; i++) tick();
    check("to_pre_berr", {31'd0, bus_err}, 32'd0);
    check("to_pre_req",  {31'd0, dm_req},  32'd1);
    tick();
    check("to_berr",  {31'd0, bus_err},  32'd1);
    check("to_wbv",   {31'd0, wb_valid}, 32'd1);
    check("to_wbwe",  {31'd0, wb_we},    32'd0);
    check("to_req",   {31'd0, dm_req},   32'd0);
    check("to_stall", {31'd0, stall},    32'd0);
    tick();
    check("to_pulse", {31'd0, bus_err}, 32'd0);

    // Ack in the final WAIT cycle beats the timeout.
    issue(5'b00000, 3'b010, 32'h0000_0500, 32'h0, 5'd11, 1'b1);
    for (int i = 0; i < 254; i++) tick();
    dm_ack = 1'b1; dm_rdata = 32'h0BAD_F00D;
    tick();
    dm_ack = 1'b0;
    check("race_berr", {31'd0, bus_err},  32'd0);
    check("race_wbv",  {31'd0, wb_valid}, 32'd1);
    check("race_data", wb_data,           32'h0BAD_F00D);
    tick();

    // Reset mid-WAIT clears outputs at once and the access is not retried.
    issue(5'b01000, 3'b010, 32'h0000_0600, 32'h5555_AAAA, 5'd0, 1'b0);
    check("rst_pre_req", {31'd0, dm_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check("norety_req",   {31'd0, dm_req}, 32'd0);
    check("noretry_stall", {31'd0, stall}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
